// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and sizing helper for serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit counter width: clog2 of the step count, never narrower than one bit.
  function automatic int cnt_width(input int width, input int digit);
    int steps;
    steps = width / digit;
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// rtl/serial_adder_digit_adder.sv - combinational DIGIT-bit ripple slice (module digit_adder).
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout  = c[DIGIT];
  // Carry into the top bit feeds the signed overflow rule on the final digit.
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder with valid/ready handshakes; SERIAL_ADDER_SUB_EN adds a subtract port.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             signed_q, signed_d, carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             sub_q, sub_d;

  logic [DIGIT-1:0] s_w;
  logic             cout_w, cmsb_w;
  logic [WIDTH-1:0] sum_shift;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (s_w),
    .cout (cout_w),
    .c_msb(cmsb_w)
  );

  // New digits enter at the top so that after STEPS shifts the LSB digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_one_step
    assign sum_shift = s_w;
  end else begin : g_multi_step
    assign sum_shift = {s_w, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    sub_d    = sub_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          carry_d  = 1'b0;
          sub_d    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d    = sub;
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          signed_d = is_signed;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = sum_shift;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = cout_w;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = cout_w;
          // Unsigned subtract reports a borrow, which is the inverted carry.
          ovf_d   = signed_q ? (cmsb_w ^ cout_w) : (cout_w ^ sub_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      sub_q    <= sub_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - checks two serial_adder builds (DIGIT=2 and DIGIT=8) against an arithmetic model.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res_t;

  logic       clk, rst_n, in_valid, is_signed, out_ready, sub_v;
  logic [7:0] a, b;
  logic       in_ready0, out_valid0, cout0, ovf0;
  logic       in_ready1, out_valid1, cout1, ovf1;
  logic [7:0] sum0, sum1;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rand_rdy = 0;
  res_t eq[2][$];
  int   tq[2][$];
  bit   seen[2];
  res_t last[2];
  int   steps_of[2] = '{4, 1};

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .is_signed(is_signed),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v),
`endif
    .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .carry_out(cout0), .overflow(ovf0)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .is_signed(is_signed),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v),
`endif
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .carry_out(cout1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rand_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  function automatic res_t model(input int av, input int bv, input bit sg, input bit sb);
    int   full, sa, sbv, sv;
    res_t r;
    full = sb ? (av + (255 - bv) + 1) : (av + bv);
    r.s  = full[7:0];
    r.c  = full[8];
    sa   = (av >= 128) ? av - 256 : av;
    sbv  = (bv >= 128) ? bv - 256 : bv;
    sv   = sb ? sa - sbv : sa + sbv;
    r.o  = sg ? (sv > 127 || sv < -128) : (sb ? !r.c : r.c);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_port(input int id, input logic ov, input logic ir, input res_t got);
    if (!ov) return;
    check($sformatf("rdy_low_in_done_%0d", id), {31'd0, ir}, 32'd0);
    if (eq[id].size() == 0) begin
      total++; bad++;
      $display("FAIL spurious_result_%0d got=%0h exp=none", id, got);
      return;
    end
    if (!seen[id]) begin
      check($sformatf("latency_%0d", id), cyc - tq[id][0], steps_of[id]);
      seen[id] = 1;
    end
    check($sformatf("result_%0d", id), {22'd0, got}, {22'd0, eq[id][0]});
    if (out_ready) begin
      last[id] = got;
      void'(eq[id].pop_front());
      void'(tq[id].pop_front());
      seen[id] = 0;
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk_port(0, out_valid0, in_ready0, {sum0, cout0, ovf0});
    chk_port(1, out_valid1, in_ready1, {sum1, cout1, ovf1});
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready0 && in_ready1) return;
    end
    total++; bad++;
    $display("FAIL wait_idle got=busy exp=idle");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eq[0].size() == 0 && eq[1].size() == 0) return;
    end
    total++; bad++;
    $display("FAIL wait_done got=%0d/%0d exp=0", eq[0].size(), eq[1].size());
  endtask

  task automatic issue(input int av, input int bv, input bit sg, input bit sb);
    res_t r;
    wait_idle();
    @(posedge clk); #1;
    a = 8'(av); b = 8'(bv); is_signed = sg; sub_v = sb; in_valid = 1'b1;
    r = model(av, bv, sg, sb);
    for (int i = 0; i < 2; i++) begin
      eq[i].push_back(r);
      tq[i].push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input int av, input int bv, input bit sg, input bit sb);
    issue(av, bv, sg, sb);
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    sub_v = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {30'd0, in_ready0, in_ready1}, 32'd3);
    check("post_rst_outs", {sum0, cout0, ovf0, sum1, cout1, ovf1}, 32'd0);

    run_op(200, 100, 1'b0, 1'b0);
    check("u200_100", {22'd0, last[0]}, {22'd0, 8'd44, 1'b1, 1'b1});
    run_op(100, 50, 1'b1, 1'b0);
    check("s100_50", {22'd0, last[0]}, {22'd0, 8'h96, 1'b0, 1'b1});
    run_op(255, 1, 1'b1, 1'b0);
    check("sFF_01", {22'd0, last[0]}, {22'd0, 8'h00, 1'b1, 1'b0});
    run_op(255, 1, 1'b0, 1'b0);
    check("uFF_01", {22'd0, last[0]}, {22'd0, 8'h00, 1'b1, 1'b1});

    // Backpressure: both units sit in DONE while in_valid toggles.
    out_ready = 1'b0;
    issue(9, 20, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !out_valid0; i++) @(negedge clk);
    check("bp_reached_done", {31'd0, out_valid0}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      a = 8'($urandom);
      @(negedge clk);
      check("bp_in_ready", {30'd0, in_ready0, in_ready1}, 32'd0);
      check("bp_hold", {sum0, cout0, ovf0}, {8'd29, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release", {30'd0, in_ready0, out_valid0}, 32'd2);
    wait_done();

    // Reset with the DIGIT=2 unit at count 1.
    issue(77, 88, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_state", {30'd0, in_ready0, out_valid0}, 32'd2);
    check("arst_outs", {sum0, cout0, ovf0}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      eq[i].delete(); tq[i].delete(); seen[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_release_ready", {31'd0, in_ready0}, 32'd1);
    run_op(3, 4, 1'b0, 1'b0);
    check("fresh_3_4", {24'd0, last[0].s}, 32'd7);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(5, 7, 1'b1, 1'b1);
    check("sub5_7_d8", {22'd0, last[1]}, {22'd0, 8'hFE, 1'b0, 1'b0});
    check("sub5_7_d2", {22'd0, last[0]}, {22'd0, 8'hFE, 1'b0, 1'b0});
`endif

    rand_rdy = 1;
    for (int n = 0; n < 150; n++) begin
      bit sb;
      sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom_range(0, 1));
`endif
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), sb);
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
